// File: rtl/reg_bank_write_port_if.sv
// Write-request bus for the register bank: valid/ready handshake carrying
// address, data and byte enables.
interface reg_bank_write_port_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_be,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_be,
    output wr_ready
  );
endinterface

// File: rtl/reg_bank_write_port.sv
// Write side of the register bank: two-stage byte-merging write path, the storage
// registers themselves, and a one-register-per-cycle clear sweep.
module reg_bank_write_port #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_R0  = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  reg_bank_write_port_if.slave         wr,
  input  logic                         clr,
  output logic [NUM_REGS*DATA_W-1:0]   q_flat,
  output logic                         wr_done,
  output logic                         clr_done,
  output logic                         busy
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q;
  logic                  pend_valid_q;
  logic [ADDR_W-1:0]     pend_addr_q;
  logic [DATA_W-1:0]     pend_data_q;
  logic [NumBytes-1:0]   pend_be_q;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic                  wr_done_q;
  logic                  clr_done_q;

  logic                  accept;
  logic                  commit_en;
  logic [DATA_W-1:0]     merged;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; clr is ignored once a sweep is running
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (clr) state_d = StClear;
      StClear: if (idx_q == LastIdx) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    wr.wr_ready = (state_q == StIdle) && !clr;
    busy        = (state_q == StClear) || pend_valid_q;
  end

  assign accept = wr.wr_valid && wr.wr_ready;

  // A hardwired-zero r0 still consumes the commit slot, so wr_done pulses anyway.
  assign commit_en = pend_valid_q && !((ZERO_R0 != 0) && (pend_addr_q == '0));

  always_comb begin
    merged = regs_q[pend_addr_q];
    for (int b = 0; b < int'(NumBytes); b++) begin
      if (pend_be_q[b]) merged[8*b +: 8] = pend_data_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_be_q    <= '0;
    end else begin
      pend_valid_q <= accept;
      if (accept) begin
        pend_addr_q <= wr.wr_addr;
        pend_data_q <= wr.wr_data;
        pend_be_q   <= wr.wr_be;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
    end else if (state_q == StIdle) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // The sweep write comes last so it would win a same-register collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(NUM_REGS); k++) regs_q[k] <= '0;
    end else begin
      if (commit_en) regs_q[pend_addr_q] <= merged;
      if (state_q == StClear) regs_q[idx_q] <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_done_q  <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      wr_done_q  <= pend_valid_q;
      clr_done_q <= (state_q == StClear) && (idx_q == LastIdx);
    end
  end

  assign wr_done  = wr_done_q;
  assign clr_done = clr_done_q;

  for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_flat
    assign q_flat[k*DATA_W +: DATA_W] = regs_q[k];
  end

endmodule

// File: tb/tb_reg_bank_write_port.sv
// Randomized and directed bench for reg_bank_write_port; two instances (ZERO_R0 = 0 and 1)
// share stimulus and are compared every cycle against a queue-based reference model.
module tb_reg_bank_write_port;
  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        clr = 1'b0;

  logic [511:0] q0, q1;
  logic done0, done1, cdone0, cdone1, busy0, busy1;

  always #5 clk = ~clk;

  reg_bank_write_port_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();
  reg_bank_write_port_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();

  assign bus0.wr_valid = wr_valid;
  assign bus0.wr_addr  = wr_addr;
  assign bus0.wr_data  = wr_data;
  assign bus0.wr_be    = wr_be;
  assign bus1.wr_valid = wr_valid;
  assign bus1.wr_addr  = wr_addr;
  assign bus1.wr_data  = wr_data;
  assign bus1.wr_be    = wr_be;

  reg_bank_write_port #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .ZERO_R0(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr(bus0.slave), .clr(clr), .q_flat(q0),
    .wr_done(done0), .clr_done(cdone0), .busy(busy0)
  );

  reg_bank_write_port #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .ZERO_R0(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr(bus1.slave), .clr(clr), .q_flat(q1),
    .wr_done(done1), .clr_done(cdone1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: register arrays, a queue of accepted-but-uncommitted writes,
  // and a sweep position while a clear is running.
  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  logic [31:0] m0 [NR];
  logic [31:0] m1 [NR];
  wr_t         pend [$];
  bit          clearing;
  int          sweep;
  bit          e_done, e_cdone;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always begin
    logic [511:0] e0, e1;
    wr_t w;
    @(posedge clk);
    if (!reset_n) begin
      for (int k = 0; k < NR; k++) begin
        m0[k] = '0;
        m1[k] = '0;
      end
      pend.delete();
      clearing = 0;
      sweep    = 0;
      e_done   = 0;
      e_cdone  = 0;
    end else begin
      e_done  = pend.size() != 0;
      e_cdone = clearing && sweep == NR - 1;
      if (pend.size() != 0) begin
        w = pend.pop_front();
        m0[w.a] = merge(m0[w.a], w.d, w.be);
        if (w.a != 0) m1[w.a] = merge(m1[w.a], w.d, w.be);
      end
      if (clearing) begin
        m0[sweep] = '0;
        m1[sweep] = '0;
        sweep++;
        if (sweep == NR) clearing = 0;
      end else if (clr) begin
        clearing = 1;
        sweep    = 0;
      end else if (wr_valid) begin
        pend.push_back('{a: wr_addr, d: wr_data, be: wr_be});
      end
    end
    #1;
    for (int k = 0; k < NR; k++) begin
      e0[k*32 +: 32] = m0[k];
      e1[k*32 +: 32] = m1[k];
    end
    chk("q_flat r0-normal", q0, e0);
    chk("q_flat r0-zero", q1, e1);
    chk("wr_ready", {510'b0, bus0.wr_ready, bus1.wr_ready}, {510'b0, {2{!clearing && !clr}}});
    chk("wr_done", {510'b0, done0, done1}, {510'b0, {2{e_done}}});
    chk("clr_done", {510'b0, cdone0, cdone1}, {510'b0, {2{e_cdone}}});
    chk("busy", {510'b0, busy0, busy1}, {510'b0, {2{clearing || pend.size() != 0}}});
  end

  int done_cnt = 0;
  int cdone_cnt = 0;
  always @(posedge clk) begin
    if (done0) done_cnt++;
    if (cdone0) cdone_cnt++;
  end

  task automatic step(input bit v, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit c);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    clr      = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 4'd0, 32'd0, 4'd0, 0);
  endtask

  initial begin
    int snap, low_cnt, cd_cnt;
    bit rdy_ok;
    repeat (2) @(negedge clk);
    chk("reset q_flat", q0, 512'd0);
    chk("reset flags", {508'b0, done0, cdone0, busy0, bus0.wr_ready}, {508'b0, 4'b0001});
    reset_n = 1'b1;
    @(negedge clk);

    // Single full-word write
    step(1, 4'd3, 32'hDEADBEEF, 4'hF, 0);
    idle(1);
    chk("t1 wr_done", {511'b0, done0}, 512'd1);
    chk("t1 reg3", {480'b0, q0[127:96]}, {480'b0, 32'hDEADBEEF});
    chk("t1 others", q0 & ~(512'hFFFFFFFF << 96), 512'd0);

    // Byte-enable merge, then empty-enable write
    step(1, 4'd5, 32'h11223344, 4'hF, 0);
    step(1, 4'd5, 32'hAABBCCDD, 4'b0101, 0);
    idle(2);
    chk("t2 merge", {480'b0, q0[5*32 +: 32]}, {480'b0, 32'h11BB33DD});
    step(1, 4'd5, 32'hFFFFFFFF, 4'h0, 0);
    idle(1);
    chk("t2 be0 done", {511'b0, done0}, 512'd1);
    chk("t2 be0 keep", {480'b0, q0[5*32 +: 32]}, {480'b0, 32'h11BB33DD});

    // Back-to-back fill
    idle(1);
    snap = done_cnt;
    rdy_ok = 1;
    for (int k = 0; k < NR; k++) begin
      wr_valid = 1; wr_addr = 4'(k); wr_data = 32'(k + 1); wr_be = 4'hF; clr = 0;
      #1 if (!bus0.wr_ready) rdy_ok = 0;
      @(negedge clk);
    end
    idle(2);
    chk("t3 ready held", {511'b0, rdy_ok}, 512'd1);
    chk("t3 done count", 512'(done_cnt - snap), 512'd16);
    for (int k = 0; k < NR; k++)
      chk("t3 reg", {480'b0, q0[k*32 +: 32]}, 512'(k + 1));

    // Clear with a colliding write and a second clr mid-sweep
    snap = done_cnt;
    step(1, 4'd7, 32'h12345678, 4'hF, 1);
    low_cnt = 0;
    cd_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      wr_valid = 0; clr = (i == 5);
      #1;
      if (!bus0.wr_ready) low_cnt++;
      if (cdone0) cd_cnt++;
      @(negedge clk);
    end
    clr = 0;
    chk("t4 ready low cycles", 512'(low_cnt), 512'd16);
    chk("t4 clr_done count", 512'(cd_cnt), 512'd1);
    chk("t4 write rejected", 512'(done_cnt - snap), 512'd0);
    chk("t4 all zero", q0, 512'd0);

    // Hardwired r0
    step(1, 4'd0, 32'hFFFFFFFF, 4'hF, 0);
    idle(1);
    chk("t5 wr_done", {511'b0, done1}, 512'd1);
    chk("t5 r0 stays 0", {480'b0, q1[31:0]}, 512'd0);
    chk("t5 r0 normal", {480'b0, q0[31:0]}, {480'b0, 32'hFFFFFFFF});

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 10) < 7, 4'($urandom), $urandom, 4'($urandom), ($urandom % 40) == 0);
    idle(20);
    for (int k = 0; k < NR; k++) step(1, 4'(k), $urandom | 32'h1, 4'hF, 0);
    idle(2);

    // Reset at sweep cycle 7
    snap = cdone_cnt;
    step(0, 4'd0, 32'd0, 4'd0, 1);
    idle(7);
    reset_n = 0;
    #1;
    chk("t6 sweep rst q0", q0, 512'd0);
    chk("t6 sweep rst q1", q1, 512'd0);
    chk("t6 sweep rst flags", {509'b0, done0, cdone0, busy0}, 512'd0);
    @(negedge clk);
    reset_n = 1;
    idle(20);
    chk("t6 no clr_done", 512'(cdone_cnt - snap), 512'd0);

    // Reset at the commit edge
    snap = done_cnt;
    step(1, 4'd2, 32'h00000055, 4'hF, 0);
    reset_n = 0;
    #1;
    chk("t6 commit rst busy", {511'b0, busy0}, 512'd0);
    @(negedge clk);
    reset_n = 1;
    idle(3);
    chk("t6 no wr_done", 512'(done_cnt - snap), 512'd0);
    chk("t6 reg2 aborted", {480'b0, q0[2*32 +: 32]}, 512'd0);
    step(1, 4'd2, 32'hCAFEF00D, 4'hF, 0);
    idle(1);
    chk("t6 write after rst", {480'b0, q0[2*32 +: 32]}, {480'b0, 32'hCAFEF00D});

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_bank_write_port.md
Name: reg_bank_write_port

Overview:
Write side of the 16 x 32-bit register bank. It accepts write requests over a valid/ready handshake and applies per-byte enables. It owns the 16 storage registers and presents them on a flat bus that feeds the bank's 16:1 read multiplexers. It also provides a sequenced clear, which zeroes one register per cycle.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
NUM_REGS, 16, number of registers.
ADDR_W, 4, register address width; must satisfy 2^ADDR_W = NUM_REGS.
ZERO_R0, 0, when 1, register 0 ignores writes and always reads 0.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
wr_valid  input  1  write request valid.
wr_ready  output  1  write port can accept; combinational.
wr_addr  input  ADDR_W  target register index.
wr_data  input  DATA_W  write data.
wr_be  input  DATA_W/8  byte enables; bit i selects byte [8i+7:8i].
clr  input  1  single-cycle request to zero all registers.
q_flat  output  NUM_REGS*DATA_W  register contents; register k occupies [k*DATA_W +: DATA_W].
wr_done  output  1  one-cycle pulse when a write commits.
clr_done  output  1  one-cycle pulse when a clear sweep completes.
busy  output  1  high while in CLEAR or while a pending write is held.

Behaviour:
- Reset (reset_n low, takes effect immediately):
  - all registers = 0; q_flat = 0
  - state = IDLE; pending write invalid
  - wr_done = 0, clr_done = 0, busy = 0
- Two-stage write:
  - Accept: a write is accepted at the edge where wr_valid && wr_ready. At that edge, wr_addr/wr_data/wr_be are captured into a pending stage.
  - Commit: at the next edge, the pending write is applied to the register file and wr_done pulses high for that one cycle.
  - Latency: the new value appears on q_flat one cycle after acceptance.
  - Back-to-back accepts are allowed every cycle, giving one commit per cycle.
- Byte merge: for each byte i, new = wr_be[i] ? wr_data byte i : old byte i.
  - wr_be = 0 leaves the register unchanged but still pulses wr_done.
  - ZERO_R0 = 1 and wr_addr = 0: the commit has no effect, and wr_done still pulses.
- Two successive writes to the same address commit in order. The second write merges onto the first write's result.
- wr_ready = (state == IDLE) && !clr.
- State machine:
  - IDLE -> CLEAR when clr = 1 at an edge; the sweep index is set to 0.
  - CLEAR: at each edge, register[index] = 0 and index increments.
  - On the edge that zeroes register NUM_REGS-1, the FSM returns to IDLE and clr_done pulses for the following cycle.
  - A clear therefore occupies exactly NUM_REGS cycles with wr_ready low.
  - clr asserted while in CLEAR is ignored; it does not restart the sweep.
- Simultaneous events:
  - clr and wr_valid in the same IDLE cycle: clr wins and the write is not accepted (wr_ready is low).
  - A pending write from the previous cycle still commits on the edge that enters CLEAR. The sweep later zeroes that register.
- busy = (state == CLEAR) || pending valid.
- Reset mid-sweep or mid-commit: the operation aborts, all state returns to reset values, and no done pulse is produced.

Test Plan:
1. Reset, then write addr 3, data 0xDEADBEEF, be 0xF -> wr_done pulses the cycle after acceptance; q_flat[127:96] = 0xDEADBEEF; all other registers stay 0.
2. Reg 5 = 0x11223344, then write data 0xAABBCCDD with be 0b0101 -> reg 5 = 0x11BB33DD; a write with be 0 leaves it unchanged and still pulses wr_done.
3. Write 16 back-to-back requests (addr k, data k+1) with wr_valid held high -> wr_ready stays high, 16 wr_done pulses occur on consecutive cycles, and reg k = k+1.
4. Fill all registers, then pulse clr together with wr_valid -> the write is rejected; wr_ready is low for 16 cycles; registers zero in index order, one per cycle; clr_done pulses once; a second clr mid-sweep does not extend it.
5. With ZERO_R0 = 1, write addr 0, data 0xFFFFFFFF -> wr_done pulses and q_flat[31:0] stays 0.
6. Drop reset_n at sweep cycle 7 and at a commit edge -> all registers and outputs read 0 immediately; no wr_done or clr_done follows; normal writes work after release.
